mem_port_sequencer: RTL and testbench
=====================================

Name: mem_port_sequencer

Overview:
- Owns the single shared 16-bit SRAM of the multi-cycle CPU.
- Arbitrates between three requesters: instruction fetch (IF), data memory (DM, LW/SW-class accesses) and the serial program loader (LD).
- Sequences each granted access into SRAM control-pin timing and returns a one-cycle done pulse to the winning requester.
- Sits between the CPU control/datapath and the board SRAM pins.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, data width.
- WAIT_CYCLES, 2, cycles OE/WE held active in PULSE state; legal range 1..15.
- FAIRNESS, 4, maximum consecutive DM grants while IF is pending before IF is forced.

Ports:
- clk  in  1  single clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  IF read request, level.
- if_addr  in  ADDR_W  IF address.
- if_done  out  1  IF access complete (1-cycle pulse).
- dm_req  in  1  DM request, level.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  DM address.
- dm_wdata  in  DATA_W  DM write data.
- dm_done  out  1  DM complete pulse.
- ld_req, ld_we, ld_addr, ld_wdata, ld_done: loader port, same meaning as the dm_* signals.
- rdata  out  DATA_W  read data, shared by all ports.
- ram_addr  out  ADDR_W  SRAM address.
- ram_dout  out  DATA_W  write data to pad.
- ram_dout_en  out  1  pad output enable.
- ram_din  in  DATA_W  data from pad.
- ram_ce_n, ram_oe_n, ram_we_n  out  1 each  SRAM strobes, active-low.
- busy  out  1  state != IDLE.
- grant_id  out  2  00 none, 01 IF, 10 DM, 11 LD.

Behaviour:
- Reset values:
  - ram_ce_n = ram_oe_n = ram_we_n = 1.
  - ram_dout_en = 0; ram_addr = 0; ram_dout = 0; rdata = 0.
  - All done outputs 0; busy = 0; grant_id = 00.
  - Fairness counter = 0; state = IDLE.
  - Reset asserted mid-access aborts it at the next edge with no done pulse; strobes deassert that same edge.
- All outputs are registered.
- States: IDLE -> SETUP -> PULSE -> FINISH -> IDLE.
- IDLE:
  - Strobes inactive.
  - If any req is high, latch the winner's addr/we/wdata, set grant_id, go to SETUP.
- Priority:
  - LD > DM > IF.
  - Exception: when IF is pending and the fairness counter equals FAIRNESS, IF wins over DM. LD still wins.
  - Counter increments on each DM grant while if_req = 1.
  - Counter clears on an IF grant, or on any arbitration where if_req = 0. It saturates at FAIRNESS.
- SETUP (1 cycle):
  - ram_ce_n = 0; ram_addr valid.
  - Read: ram_oe_n = 0.
  - Write: ram_dout_en = 1, ram_dout valid, ram_we_n = 1.
- PULSE (WAIT_CYCLES cycles, 4-bit down-counter):
  - Read: ram_oe_n = 0.
  - Write: ram_we_n = 0.
  - Read only: on the last PULSE cycle, rdata <= ram_din.
- FINISH (1 cycle):
  - ram_we_n = 1 and ram_oe_n = 1.
  - ram_ce_n = 0, and addr/dout/dout_en held, giving write hold time.
  - The granted port's done = 1.
  - Next state IDLE; strobes go inactive.
- Latency: req sampled high in IDLE at cycle 0 -> done at cycle 2+WAIT_CYCLES (4 at default). Minimum spacing between accesses is 3+WAIT_CYCLES cycles.
- rdata stays valid from the FINISH cycle until the next read's last PULSE edge. Writes never change rdata.
- Handshake:
  - Requester holds req, addr, we and wdata stable from assertion until done.
  - Requester drops req on the edge that samples done = 1. A req still high in the following IDLE cycle starts a new access (legal back-to-back).
  - Inputs are ignored outside IDLE; a req change mid-access has no effect.
- Simultaneous reqs: exactly one grant per arbitration. Losers stay pending and are served in later IDLE cycles.
- ram_dout_en and ram_oe_n = 0 are never asserted in the same cycle.

Test Plan:
- Single IF read, addr 0x00010, ram_din model returns 0x1234 -> if_done at cycle 4, rdata = 0x1234, ram_oe_n low cycles 1-3, grant_id = 01 during access.
- DM write addr 0x3FFFF data 0xBEEF -> ram_we_n low exactly cycles 2-3, ram_dout_en high cycles 1-4, dm_done at cycle 4, rdata unchanged.
- if_req and dm_req (read) asserted together and held continuously (re-requesting after each done) -> DM granted 4 times consecutively, then IF on the 5th grant, then DM again; fairness counter returns to 0.
- ld_req, dm_req and if_req all high -> grant order LD, DM, IF; each done pulses exactly once; no done overlaps.
- rst pulsed during PULSE of a write -> next edge: ram_we_n = 1, ram_ce_n = 1, ram_dout_en = 0, state IDLE, no dm_done; a request still held afterwards is re-served from SETUP.
- WAIT_CYCLES = 1 and WAIT_CYCLES = 15 builds -> done at cycles 3 and 17 respectively; data sampled on the last PULSE cycle.

Source files
------------

// File: rtl/mem_port_sequencer.sv
// Shared SRAM port sequencer: arbitrates IF / DM / loader requests
// and drives SETUP -> PULSE -> FINISH strobe timing on the SRAM pins.
module mem_port_sequencer #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int FAIRNESS    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_dout,
    output logic              ram_dout_en,
    input  logic [DATA_W-1:0] ram_din,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              busy,
    output logic [1:0]        grant_id
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_PULSE  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_IF   = 2'd1;
    localparam logic [1:0] G_DM   = 2'd2;
    localparam logic [1:0] G_LD   = 2'd3;

    localparam int FW = $clog2(FAIRNESS + 1);
    localparam logic [FW-1:0] FAIR_MAX  = FW'(FAIRNESS);
    localparam logic [3:0]    WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]        state_q, state_d;
    logic [3:0]        pcnt_q, pcnt_d;
    logic [FW-1:0]     fair_q, fair_d;
    logic              we_q, we_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_en_q, dout_en_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              ld_done_q, ld_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              if_force;
    logic [1:0]        win;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    // Pick the winner: LD first, then DM unless a starved IF is forced.
    always_comb begin
        if_force  = if_req && (fair_q == FAIR_MAX);
        win       = G_NONE;
        win_we    = 1'b0;
        win_addr  = if_addr;
        win_wdata = dm_wdata;
        if (ld_req) begin
            win = G_LD;
        end else if (dm_req && !if_force) begin
            win = G_DM;
        end else if (if_req) begin
            win = G_IF;
        end
        case (win)
            G_DM: begin
                win_we    = dm_we;
                win_addr  = dm_addr;
                win_wdata = dm_wdata;
            end
            G_LD: begin
                win_we    = ld_we;
                win_addr  = ld_addr;
                win_wdata = ld_wdata;
            end
            default: begin
                win_we    = 1'b0;
                win_addr  = if_addr;
                win_wdata = dm_wdata;
            end
        endcase
    end

    // Next-state and next-pin values; every pin is a flop output.
    always_comb begin
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        fair_d    = fair_q;
        we_d      = we_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        dout_en_d = dout_en_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        rdata_d   = rdata_q;
        if_done_d = 1'b0;
        dm_done_d = 1'b0;
        ld_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win != G_NONE) begin
                    state_d   = S_SETUP;
                    grant_d   = win;
                    addr_d    = win_addr;
                    we_d      = win_we;
                    dout_en_d = win_we;
                    ce_n_d    = 1'b0;
                    oe_n_d    = win_we;
                    we_n_d    = 1'b1;
                    if (win_we) begin
                        dout_d = win_wdata;
                    end
                    if (!if_req || win == G_IF) begin
                        fair_d = '0;
                    end else if (win == G_DM && fair_q != FAIR_MAX) begin
                        fair_d = fair_q + 1'b1;
                    end
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                pcnt_d  = WAIT_LOAD;
                oe_n_d  = we_q;
                we_n_d  = !we_q;
            end
            S_PULSE: begin
                if (pcnt_q <= 4'd1) begin
                    state_d   = S_FINISH;
                    oe_n_d    = 1'b1;
                    we_n_d    = 1'b1;
                    if_done_d = (grant_q == G_IF);
                    dm_done_d = (grant_q == G_DM);
                    ld_done_d = (grant_q == G_LD);
                    if (!we_q) begin
                        rdata_d = ram_din;
                    end
                end else begin
                    pcnt_d = pcnt_q - 4'd1;
                end
            end
            S_FINISH: begin
                state_d   = S_IDLE;
                ce_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                we_n_d    = 1'b1;
                dout_en_d = 1'b0;
                grant_d   = G_NONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and pin registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pcnt_q    <= 4'd0;
            fair_q    <= '0;
            we_q      <= 1'b0;
            grant_q   <= G_NONE;
            addr_q    <= '0;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            if_done_q <= 1'b0;
            dm_done_q <= 1'b0;
            ld_done_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            fair_q    <= fair_d;
            we_q      <= we_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            if_done_q <= if_done_d;
            dm_done_q <= dm_done_d;
            ld_done_q <= ld_done_d;
            rdata_q   <= rdata_d;
        end
    end

    assign if_done     = if_done_q;
    assign dm_done     = dm_done_q;
    assign ld_done     = ld_done_q;
    assign rdata       = rdata_q;
    assign ram_addr    = addr_q;
    assign ram_dout    = dout_q;
    assign ram_dout_en = dout_en_q;
    assign ram_ce_n    = ce_n_q;
    assign ram_oe_n    = oe_n_q;
    assign ram_we_n    = we_n_q;
    assign busy        = (state_q != S_IDLE);
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: transaction-timeline model checked
// every cycle, plus literal expectations for latency, order and reset.
module tb_mem_port_sequencer;

    localparam int AW   = 18;
    localparam int DW   = 16;
    localparam int W    = 2;
    localparam int FAIR = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          ld_req = 1'b0;
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic [DW-1:0] ram_din;
    wire           if_done, dm_done, ld_done;
    wire [DW-1:0]  rdata, ram_dout;
    wire [AW-1:0]  ram_addr;
    wire           ram_dout_en, ram_ce_n, ram_oe_n, ram_we_n, busy;
    wire [1:0]     grant_id;

    logic          r1_req = 1'b0, r15_req = 1'b0;
    logic [DW-1:0] din1 = '0, din15 = '0;
    wire           w1_if_done, w1_dm_done, w1_ld_done;
    wire           w15_if_done, w15_dm_done, w15_ld_done;
    wire [DW-1:0]  w1_rdata, w1_dout, w15_rdata, w15_dout;
    wire [AW-1:0]  w1_addr, w15_addr;
    wire           w1_en, w1_ce, w1_oe, w1_we, w1_busy;
    wire           w15_en, w15_ce, w15_oe, w15_we, w15_busy;
    wire [1:0]     w1_gid, w15_gid;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] din_fn(input logic [AW-1:0] a);
        if (a == 18'h00010) return 16'h1234;
        return a[15:0] ^ 16'h5A5A;
    endfunction

    assign ram_din = din_fn(ram_addr);

    mem_port_sequencer dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_done(dm_done),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_done(ld_done),
        .rdata(rdata), .ram_addr(ram_addr), .ram_dout(ram_dout),
        .ram_dout_en(ram_dout_en), .ram_din(ram_din),
        .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .busy(busy), .grant_id(grant_id)
    );

    mem_port_sequencer #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst),
        .if_req(r1_req), .if_addr(18'h00ABC), .if_done(w1_if_done),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(18'h0),
        .dm_wdata(16'h0), .dm_done(w1_dm_done),
        .ld_req(1'b0), .ld_we(1'b0), .ld_addr(18'h0),
        .ld_wdata(16'h0), .ld_done(w1_ld_done),
        .rdata(w1_rdata), .ram_addr(w1_addr), .ram_dout(w1_dout),
        .ram_dout_en(w1_en), .ram_din(din1),
        .ram_ce_n(w1_ce), .ram_oe_n(w1_oe), .ram_we_n(w1_we),
        .busy(w1_busy), .grant_id(w1_gid)
    );

    mem_port_sequencer #(.WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst(rst),
        .if_req(r15_req), .if_addr(18'h00DEF), .if_done(w15_if_done),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(18'h0),
        .dm_wdata(16'h0), .dm_done(w15_dm_done),
        .ld_req(1'b0), .ld_we(1'b0), .ld_addr(18'h0),
        .ld_wdata(16'h0), .ld_done(w15_ld_done),
        .rdata(w15_rdata), .ram_addr(w15_addr), .ram_dout(w15_dout),
        .ram_dout_en(w15_en), .ram_din(din15),
        .ram_ce_n(w15_ce), .ram_oe_n(w15_oe), .ram_we_n(w15_we),
        .busy(w15_busy), .grant_id(w15_gid)
    );

    // Model: m_off = cycles into the current access (0 = idle).
    int            m_off = 0;
    int            m_fair = 0;
    logic [1:0]    m_grant = 2'd0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_dout = '0;
    logic [DW-1:0] m_rdata = '0;

    always @(posedge clk) begin : model
        int g;
        g = 0;
        if (rst) begin
            m_off = 0; m_fair = 0; m_grant = 2'd0; m_we = 1'b0;
            m_addr = '0; m_dout = '0; m_rdata = '0;
        end else if (m_off == 0) begin
            if (ld_req) g = 3;
            else if (dm_req && !(if_req && m_fair == FAIR)) g = 2;
            else if (if_req) g = 1;
            if (g != 0) begin
                if (!if_req || g == 1) m_fair = 0;
                else if (g == 2 && m_fair < FAIR) m_fair = m_fair + 1;
                m_grant = 2'(g);
                m_off = 1;
                if (g == 1) begin
                    m_addr = if_addr; m_we = 1'b0;
                end else if (g == 2) begin
                    m_addr = dm_addr; m_we = dm_we;
                    if (dm_we) m_dout = dm_wdata;
                end else begin
                    m_addr = ld_addr; m_we = ld_we;
                    if (ld_we) m_dout = ld_wdata;
                end
            end
        end else if (m_off == W + 2) begin
            m_off = 0;
        end else begin
            if (m_off == W + 1 && !m_we) m_rdata = din_fn(m_addr);
            m_off = m_off + 1;
        end
    end

    int checks = 0;
    int failures = 0;
    int if_cnt = 0, dm_cnt = 0, ld_cnt = 0;
    int order[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_cycle();
        logic pul, act;
        pul = (m_off >= 2 && m_off <= W + 1);
        act = (m_off != 0);
        chk("busy", busy, act);
        chk("grant_id", grant_id, act ? m_grant : 2'd0);
        chk("ce_n", ram_ce_n, !act);
        chk("oe_n", ram_oe_n, !(m_off >= 1 && m_off <= W + 1 && !m_we));
        chk("we_n", ram_we_n, !(pul && m_we));
        chk("dout_en", ram_dout_en, act && m_we);
        chk("if_done", if_done, m_off == W + 2 && m_grant == 2'd1);
        chk("dm_done", dm_done, m_off == W + 2 && m_grant == 2'd2);
        chk("ld_done", ld_done, m_off == W + 2 && m_grant == 2'd3);
        chk("ram_addr", ram_addr, m_addr);
        chk("ram_dout", ram_dout, m_dout);
        chk("rdata", rdata, m_rdata);
        chk("oe_en_excl", !ram_oe_n && ram_dout_en, 0);
    endtask

    // One cycle: compare, then act as the three requesters.
    task automatic step();
        @(negedge clk);
        check_cycle();
        if (if_done && if_cnt > 0) begin
            order.push_back(1); if_cnt--;
            if (if_cnt == 0) if_req = 1'b0;
            else if_addr = if_addr + 1'b1;
        end
        if (dm_done && dm_cnt > 0) begin
            order.push_back(2); dm_cnt--;
            if (dm_cnt == 0) dm_req = 1'b0;
            else begin dm_addr = dm_addr + 1'b1; dm_wdata = dm_wdata + 1'b1; end
        end
        if (ld_done && ld_cnt > 0) begin
            order.push_back(3); ld_cnt--;
            if (ld_cnt == 0) ld_req = 1'b0;
            else begin ld_addr = ld_addr + 1'b1; ld_wdata = ld_wdata + 1'b1; end
        end
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while ((if_cnt != 0 || dm_cnt != 0 || ld_cnt != 0 || busy) && n < bound) begin
            step();
            n++;
        end
        chk(name, n < bound, 1);
    endtask

    task automatic single(input int port, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output int done_k,
                          output logic [31:0] oe_m, output logic [31:0] we_m,
                          output logic [31:0] en_m, output logic [31:0] g_m);
        logic dn;
        oe_m = 0; we_m = 0; en_m = 0; g_m = 0; done_k = -1;
        if (port == 1) begin if_addr = a; if_cnt = 1; if_req = 1'b1; end
        else if (port == 2) begin
            dm_we = we; dm_addr = a; dm_wdata = d; dm_cnt = 1; dm_req = 1'b1;
        end else begin
            ld_we = we; ld_addr = a; ld_wdata = d; ld_cnt = 1; ld_req = 1'b1;
        end
        for (int k = 1; k <= 30 && done_k < 0; k++) begin
            step();
            oe_m[k] = !ram_oe_n;
            we_m[k] = !ram_we_n;
            en_m[k] = ram_dout_en;
            g_m[k]  = (grant_id == 2'(port));
            dn = (port == 1) ? if_done : (port == 2) ? dm_done : ld_done;
            if (dn) done_k = k;
        end
        chk("single_timeout", done_k > 0, 1);
        step();
    endtask

    int          dk, k1, k15, rk;
    logic [31:0] oe_m, we_m, en_m, g_m;
    int          exp_f[6] = '{2, 2, 2, 2, 1, 2};
    int          exp_a[3] = '{3, 2, 1};

    initial begin
        step();
        rst = 1'b0;
        chk("rst_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_dout_en}, 4'b1110);
        chk("rst_busy_gid", {busy, grant_id}, 3'b000);
        chk("rst_done", {if_done, dm_done, ld_done}, 3'b000);
        chk("rst_addr", ram_addr, 0);
        chk("rst_rdata", rdata, 0);
        step();

        single(1, 1'b0, 18'h00010, 16'h0, dk, oe_m, we_m, en_m, g_m);
        chk("if_done_cycle", dk, 4);
        chk("if_oe_cycles", oe_m, 32'h0000000E);
        chk("if_grant_cycles", g_m, 32'h0000001E);
        chk("if_rdata", rdata, 16'h1234);

        single(2, 1'b1, 18'h3FFFF, 16'hBEEF, dk, oe_m, we_m, en_m, g_m);
        chk("dm_done_cycle", dk, 4);
        chk("dm_we_cycles", we_m, 32'h0000000C);
        chk("dm_en_cycles", en_m, 32'h0000001E);
        chk("dm_oe_cycles", oe_m, 0);
        chk("dm_rdata_kept", rdata, 16'h1234);
        chk("dm_dout", ram_dout, 16'hBEEF);

        order.delete();
        if_addr = 18'h00100; dm_we = 1'b0; dm_addr = 18'h00200;
        if_cnt = 1; dm_cnt = 5; if_req = 1'b1; dm_req = 1'b1;
        drain("fair_timeout", 200);
        chk("fair_len", order.size(), 6);
        for (int i = 0; i < 6 && i < order.size(); i++)
            chk($sformatf("fair_order%0d", i), order[i], exp_f[i]);

        order.delete();
        ld_we = 1'b1; ld_addr = 18'h00300; ld_wdata = 16'h5555;
        dm_we = 1'b0; dm_addr = 18'h00201; if_addr = 18'h00101;
        ld_cnt = 1; dm_cnt = 1; if_cnt = 1;
        ld_req = 1'b1; dm_req = 1'b1; if_req = 1'b1;
        drain("all3_timeout", 100);
        chk("all3_len", order.size(), 3);
        for (int i = 0; i < 3 && i < order.size(); i++)
            chk($sformatf("all3_order%0d", i), order[i], exp_a[i]);

        order.delete();
        dm_we = 1'b1; dm_addr = 18'h00400; dm_wdata = 16'hCAFE;
        dm_cnt = 1; dm_req = 1'b1;
        step();
        step();
        chk("pre_rst_we_n", ram_we_n, 0);
        rst = 1'b1;
        step();
        chk("abort_strobes", {ram_ce_n, ram_we_n, ram_dout_en}, 3'b110);
        chk("abort_idle", {busy, dm_done}, 2'b00);
        rst = 1'b0;
        rk = -1;
        for (int k = 1; k <= 20 && rk < 0; k++) begin
            step();
            if (dm_done) rk = k;
        end
        chk("reserve_done_cycle", rk, 4);
        drain("reserve_timeout", 20);
        chk("reserve_done_once", order.size(), 1);

        k1 = -1; k15 = -1;
        din1 = 16'h0BAD; din15 = 16'h0BAD;
        r1_req = 1'b1; r15_req = 1'b1;
        for (int k = 1; k <= 40 && (k1 < 0 || k15 < 0); k++) begin
            step();
            din1  = (k == 2)  ? 16'hC0DE : 16'h0BAD;
            din15 = (k == 16) ? 16'hC0DE : 16'h0BAD;
            if (w1_if_done && k1 < 0) begin k1 = k; r1_req = 1'b0; end
            if (w15_if_done && k15 < 0) begin k15 = k; r15_req = 1'b0; end
        end
        chk("w1_done_cycle", k1, 3);
        chk("w15_done_cycle", k15, 17);
        chk("w1_rdata", w1_rdata, 16'hC0DE);
        chk("w15_rdata", w15_rdata, 16'hC0DE);
        step();
        step();
        chk("w1_idle", {w1_busy, w1_gid, w1_ce, w1_oe, w1_we, w1_en}, 7'b0001110);
        chk("w15_idle", {w15_busy, w15_gid, w15_ce, w15_oe, w15_we, w15_en}, 7'b0001110);
        chk("w_other_done", {w1_dm_done, w1_ld_done, w15_dm_done, w15_ld_done}, 0);
        chk("w1_addr", w1_addr, 18'h00ABC);
        chk("w15_addr", w15_addr, 18'h00DEF);
        chk("w_dout", {w1_dout, w15_dout}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
